// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the vector processor.
// Owns the PC, addresses the combinational instruction ROM and registers the
// returned word into the IF/ID pipeline register. It handles stall, branch
// redirect with squash, and an end-of-program halt.
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_count and
// stall_count performance counters.
//
// Handshake note: there is no valid/ready pair on the ROM side. The ROM
// answers in the same cycle. Toward decode, if_id_valid marks a real
// instruction. stall is decode's back-pressure, and while it is high the
// IF/ID contents are held unchanged.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PROG_END = 32'd168
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    // The halted output is the state register itself.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic         valid_q, valid_d;
    logic         misalign_q, misalign_d;
    logic         at_end;

    assign at_end = (pc_q == PROG_END);

    // Next-state logic. Priority is branch > halt > stall > advance.
    // Reset is applied in the register block and takes precedence over all of these.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        if (branch_taken) begin
            // Redirect: force word alignment, squash IF/ID, and leave halt.
            pc_d    = {branch_target[31:2], 2'b00};
            instr_d = 32'h0;
            id_pc_d = 32'h0;
            valid_d = 1'b0;
            state_d = ST_RUN;
            if (branch_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (at_end) begin
            // Parked at the end of the program. The PC holds.
            // IF/ID drains to a nop unless decode is stalling.
            state_d = ST_HALT;
            if (!stall) begin
                instr_d = 32'h0;
                id_pc_d = 32'h0;
                valid_d = 1'b0;
            end
        end else if (!stall) begin
            instr_d = rom_data;
            id_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            // Raise halted on the same edge that the PC reaches the end.
            if (pc_d == PROG_END) begin
                state_d = ST_HALT;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            id_pc_q    <= 32'h0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counter increments follow the same priority as the PC update.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!branch_taken && !at_end) begin
            if (stall) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end else begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers. Both counters wrap silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

    assign rom_addr     = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc     = id_pc_q;
    assign if_id_valid  = valid_q;
    assign halted       = (state_q == ST_HALT);
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a 42-word ROM model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rom [0:41];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .misalign_err (misalign_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  // combinational ROM model
  assign rom_data = (rom_addr < 32'd168) ? rom[rom_addr[7:2]] : 32'h0;

  // driver: advance one edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 42; i++) rom[i] = 32'hC0DE_0000 | i;
    rom[0]  = 32'h1802000A;
    rom[4]  = 32'h70200000;
    rom[24] = 32'h4C816002;

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    step();
    check("rst_rom_addr", rom_addr, 32'd0);
    check("rst_valid", {31'h0, if_id_valid}, 32'd0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_id_pc", if_id_pc, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'd0);
    check("rst_misalign", {31'h0, misalign_err}, 32'd0);

    // free run to halt
    reset = 1'b0;
    step();
    check("first_id_pc", if_id_pc, 32'd0);
    check("first_instr", if_id_instr, 32'h1802000A);
    check("first_valid", {31'h0, if_id_valid}, 32'd1);
    check("first_rom_addr", rom_addr, 32'd4);
    repeat (40) step();
    check("pre_halt_halted", {31'h0, halted}, 32'd0);
    check("pre_halt_addr", rom_addr, 32'd164);
    step();
    check("halt_halted", {31'h0, halted}, 32'd1);
    check("halt_addr", rom_addr, 32'd168);
    check("halt_last_pc", if_id_pc, 32'd164);
    check("halt_last_instr", if_id_instr, 32'hC0DE_0029);
    check("halt_last_valid", {31'h0, if_id_valid}, 32'd1);
    step();
    check("halt_drain_valid", {31'h0, if_id_valid}, 32'd0);
    check("halt_drain_instr", if_id_instr, 32'h0);
    check("halt_hold_addr", rom_addr, 32'd168);
    check("halt_hold_halted", {31'h0, halted}, 32'd1);

    // branch out of halt
    branch_taken = 1'b1; branch_target = 32'd0;
    step();
    branch_taken = 1'b0;
    check("unhalt_halted", {31'h0, halted}, 32'd0);
    check("unhalt_addr", rom_addr, 32'd0);
    check("unhalt_valid", {31'h0, if_id_valid}, 32'd0);
    step();
    check("restart_id_pc", if_id_pc, 32'd0);
    check("restart_instr", if_id_instr, 32'h1802000A);
    check("restart_valid", {31'h0, if_id_valid}, 32'd1);

    // stall 3 cycles at PC=16
    repeat (3) step();
    check("pre_stall_addr", rom_addr, 32'd16);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", rom_addr, 32'd16);
      check("stall_id_pc", if_id_pc, 32'd12);
      check("stall_instr", if_id_instr, 32'hC0DE_0003);
      check("stall_valid", {31'h0, if_id_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    check("unstall_id_pc", if_id_pc, 32'd16);
    check("unstall_instr", if_id_instr, 32'h70200000);
    check("unstall_addr", rom_addr, 32'd20);

    // branch together with stall
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd96;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    check("br_addr", rom_addr, 32'd96);
    check("br_valid", {31'h0, if_id_valid}, 32'd0);
    check("br_instr", if_id_instr, 32'h0);
    step();
    check("br_tgt_id_pc", if_id_pc, 32'd96);
    check("br_tgt_instr", if_id_instr, 32'h4C816002);
    check("br_tgt_valid", {31'h0, if_id_valid}, 32'd1);

    // misaligned branch, then aligned branch, then reset
    branch_taken = 1'b1; branch_target = 32'h62;
    step();
    branch_taken = 1'b0;
    check("mis_addr", rom_addr, 32'h60);
    check("mis_err", {31'h0, misalign_err}, 32'd1);
    step();
    check("mis_tgt_id_pc", if_id_pc, 32'h60);
    branch_taken = 1'b1; branch_target = 32'd8;
    step();
    branch_taken = 1'b0;
    check("mis_sticky", {31'h0, misalign_err}, 32'd1);
    check("al_addr", rom_addr, 32'd8);
    reset = 1'b1;
    step();
    check("mis_clear", {31'h0, misalign_err}, 32'd0);
    check("mis_rst_addr", rom_addr, 32'd0);

    // reset while stalled and branching
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd40;
    step();
    check("rst_mid_addr", rom_addr, 32'd0);
    check("rst_mid_valid", {31'h0, if_id_valid}, 32'd0);
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    step();
    check("rst_mid_first_pc", if_id_pc, 32'd0);
    check("rst_mid_first_valid", {31'h0, if_id_valid}, 32'd1);

`ifdef FETCH_PERF_CNT_EN
    reset = 1'b1;
    step();
    check("perf_rst_fetch", fetch_count, 32'd0);
    check("perf_rst_stall", stall_count, 32'd0);
    reset = 1'b0;
    repeat (5) step();
    stall = 1'b1;
    repeat (2) step();
    stall = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (halted) break;
      step();
    end
    check("perf_halted", {31'h0, halted}, 32'd1);
    check("perf_stall_count", stall_count, 32'd2);
    check("perf_fetch_count", fetch_count, 32'd42);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the vector processor. Owns the program counter, drives the word address into the combinational instruction ROM and captures the returned word into the IF/ID pipeline register. It handles stall, branch redirect, squash and an end-of-program halt. It sits directly upstream of decode and is the only master of the instruction ROM address bus.

## Interface
- `RESET_PC`, 32'd0 — byte address loaded into PC on reset; must be word-aligned.
- `PROG_END`, 32'd168 — byte address one past the last program word (42 words); fetch halts when PC reaches it.
- `clk` in 1 — single clock; all state updates on rising edge.
- `reset` in 1 — synchronous, active-high; sampled on rising edge of `clk`.
- `stall` in 1 — decode back-pressure; holds PC and IF/ID.
- `branch_taken` in 1 — redirect request from execute.
- `branch_target` in 32 — byte address of redirect.
- `rom_addr` out 32 — byte address to instruction ROM; combinational copy of PC.
- `rom_data` in 32 — instruction word returned combinationally by ROM.
- `if_id_instr` out 32 — registered instruction to decode.
- `if_id_pc` out 32 — registered byte address of `if_id_instr`.
- `if_id_valid` out 1 — `if_id_instr` is a real fetched instruction.
- `halted` out 1 — PC has reached `PROG_END`.
- `misalign_err` out 1 — sticky: a branch target had nonzero bits [1:0].

## Operation
- Per-cycle priority: `reset` > `branch_taken` > halt > `stall` > sequential advance.
- `reset`: PC=`RESET_PC`; `if_id_instr`=32'h0 (nop); `if_id_pc`=0; `if_id_valid`=0; `halted`=0; `misalign_err`=0.
- `branch_taken`: PC={`branch_target`[31:2],2'b00}; IF/ID squashed (instr=0, valid=0, pc=0); `halted` cleared. Overrides `stall` and halt. If `branch_target`[1:0]≠0, `misalign_err` sets and stays set until reset.
- Halt: when PC==`PROG_END` and no branch, `halted`=1, PC holds, and IF/ID loads a nop with valid=0 unless stalled. Leaving halt requires reset or branch.
- `stall` (no branch, not halted): PC, `if_id_instr`, `if_id_pc` and `if_id_valid` all hold.
- Advance: `if_id_instr`<=`rom_data`; `if_id_pc`<=PC; `if_id_valid`<=1; PC<=PC+4.
- PC arithmetic is 32-bit unsigned and wraps at 2^32 with no flag. `PROG_END` is normally reached first.
- `rom_addr` always equals PC, including during stall, halt and the reset cycle.

## Timing
- `rom_addr` is combinational from the PC register; ROM is combinational; the fetch-to-IF/ID latency is 1 cycle.
- The word at address A appears on `if_id_instr` in the cycle after PC==A.
- Branch asserted in cycle N: PC=target in N+1; the target instruction is valid on IF/ID in N+2. This is a one-bubble penalty.
- `halted` rises in the same edge that PC first reaches `PROG_END`. The last valid instruction (`PROG_END`-4) is on IF/ID in that cycle.
- Reset mid-stall or mid-branch: reset values win at that edge; the first valid instruction appears 1 cycle after reset deasserts.
- All outputs are registered except `rom_addr`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - adds outputs `fetch_count` (32) and `stall_count` (32), both cleared on reset;
  - `fetch_count` increments on each advance edge;
  - `stall_count` increments on each edge with `stall`=1, no branch and not halted;
  - both wrap at 2^32.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Reset then free-run with ROM loaded 42 words:
  - cycle 1 after reset: `if_id_pc`=0, `if_id_instr`=32'h1802000A, valid=1;
  - `halted`=1 when PC=168;
  - `if_id_pc`=164 is the last valid word.
- Stall held 3 cycles with PC=16:
  - PC stays 16 throughout;
  - `if_id_instr`/`if_id_pc`=12 held;
  - after release, the next valid is `if_id_pc`=16, instr 32'h70200000.
- `branch_taken` with target 96 in the same cycle as `stall`=1:
  - next cycle PC=96, IF/ID valid=0, instr=0;
  - following cycle `if_id_pc`=96, instr 32'h4C816002.
- Branch to target 0x62 (misaligned):
  - PC=0x60;
  - `misalign_err`=1 and remains 1 after a later aligned branch;
  - clears only on reset.
- While halted, branch to 0:
  - `halted`=0 next cycle;
  - fetch restarts, `if_id_pc`=0 two cycles after the branch.
- With `FETCH_PERF_CNT_EN`, free-run plus one 2-cycle stall:
  - `stall_count`=2;
  - `fetch_count`=42 at halt.
